watchdog_reset: RTL
===================

WATCHDOG_RESET -- requirements
Module: watchdog_reset

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: edges from arm or kick until the reset request.
REQ-002 Parameter WARN_CYCLES, default 65536: remaining-cycle count at which the early warning asserts.
REQ-003 Parameter BITE_CYCLES, default 8: width in cycles of the reset request pulse.
REQ-004 Parameter CNT_W, default 24: width of the remaining-cycle counter.
REQ-005 clk  input  1  sole clock; all logic on posedge clk.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 enable  input  1  level; high arms the watchdog, low disarms it.
REQ-008 kick  input  1  sampled each edge; high restarts the timeout.
REQ-009 clear_cause  input  1  sampled each edge; high clears timed_out.
REQ-010 warn  output  1  high while state is WARN.
REQ-011 bite  output  1  reset request to the system reset generator; high while state is BITE.
REQ-012 timed_out  output  1  sticky flag: a bite has occurred.
REQ-013 remaining  output  CNT_W  current countdown value.

Function
REQ-014 Legal parameters: 1 <= WARN_CYCLES < TIMEOUT_CYCLES < 2^CNT_W and BITE_CYCLES >= 1; the module SHALL fail elaboration otherwise.
REQ-015 The module SHALL implement four states: IDLE, ARMED, WARN, BITE; warn, bite and remaining are registered.
REQ-016 IDLE: remaining=0; enable=1 at an edge -> ARMED, remaining=TIMEOUT_CYCLES.
REQ-017 ARMED/WARN, no kick, enable=1: remaining decrements by 1 at every edge.
REQ-018 ARMED: when the decremented value equals WARN_CYCLES, the state SHALL become WARN on that same edge.
REQ-019 WARN: at an edge with remaining==1 -> BITE, remaining=0, timed_out set.
REQ-020 Timing: arm at edge E with no kick -> warn high after edge E+TIMEOUT_CYCLES-WARN_CYCLES; bite high after edge E+TIMEOUT_CYCLES.
REQ-021 kick=1 in ARMED or WARN -> remaining=TIMEOUT_CYCLES, state ARMED; kick overrides a WARN->BITE transition at the same edge.
REQ-022 kick in IDLE or BITE SHALL be ignored.
REQ-023 enable=0 in ARMED or WARN -> IDLE, remaining=0; enable overrides a simultaneous kick or timeout.
REQ-024 BITE is non-abortable by enable or kick.
REQ-025 BITE SHALL last exactly BITE_CYCLES cycles, timed by an internal pulse counter, then -> IDLE.
REQ-026 From IDLE after BITE, the block re-arms at the next edge with enable=1.
REQ-027 timed_out SHALL set on entry to BITE and clear on an edge with clear_cause=1; set wins on a simultaneous set and clear.

Reset
REQ-028 rst=1 at an edge -> state IDLE, remaining=0, warn=0, bite=0, pulse counter=0; the same applies mid-BITE, dropping bite at that edge.
REQ-029 timed_out SHALL NOT be affected by rst; its power-up initial value is 0, so the cause survives the system reset the bite itself triggers.
REQ-030 All registers have power-up initial values equal to their reset values, so the block is defined before the first rst.

Verification (TIMEOUT_CYCLES=20, WARN_CYCLES=5, BITE_CYCLES=3, CNT_W=8)
REQ-031 rst, then enable=1 at edge 0, no kick -> warn=1 from edge 15; bite=1 after edges 20-22, bite=0 after edge 23; timed_out=1; remaining=0.
REQ-032 enable=1 with kick every 10 cycles for 200 cycles -> warn and bite never assert, remaining never below 10.
REQ-033 kick at the edge where remaining==1 in WARN -> no bite, remaining=20, warn=0 next cycle.
REQ-034 enable dropped at remaining==3 in WARN -> IDLE, warn=0, remaining=0, timed_out unchanged; a later kick has no effect.
REQ-035 rst asserted during the 2nd bite cycle -> bite=0 after that edge, timed_out stays 1.
REQ-036 clear_cause=1 on the edge that enters BITE -> timed_out=1; clear_cause alone later -> timed_out=0.

Source files
------------

// File: rtl/watchdog_reset_if.sv
// Watchdog control/status bundle: controller side drives enable/kick/clear_cause,
// the watchdog drives warn/bite/timed_out/remaining.
interface watchdog_reset_if #(
    parameter int unsigned CNT_W = 24
);
    logic             enable;
    logic             kick;
    logic             clear_cause;
    logic             warn;
    logic             bite;
    logic             timed_out;
    logic [CNT_W-1:0] remaining;

    modport master (
        output enable,
        output kick,
        output clear_cause,
        input  warn,
        input  bite,
        input  timed_out,
        input  remaining
    );

    modport slave (
        input  enable,
        input  kick,
        input  clear_cause,
        output warn,
        output bite,
        output timed_out,
        output remaining
    );
endinterface

// File: rtl/watchdog_reset.sv
// Countdown watchdog: arms on enable, warns near expiry, then issues a fixed-width
// reset-request pulse and records the cause in a flag that survives rst.
module watchdog_reset #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned WARN_CYCLES    = 65536,
    parameter int unsigned BITE_CYCLES    = 8,
    parameter int unsigned CNT_W          = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    watchdog_reset_if.slave         wd
);

    localparam int unsigned BiteW = (BITE_CYCLES > 1) ? $clog2(BITE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WarnVal    = CNT_W'(WARN_CYCLES);
    localparam logic [BiteW-1:0] BiteLast   = BiteW'(BITE_CYCLES - 1);

    generate
        if (!((WARN_CYCLES >= 1) && (WARN_CYCLES < TIMEOUT_CYCLES) &&
              (64'(TIMEOUT_CYCLES) < (64'd1 << CNT_W)) && (BITE_CYCLES >= 1))) begin : g_bad_params
            $error("watchdog_reset: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StWarn  = 2'd2,
        StBite  = 2'd3
    } state_e;

    // Initialisers give a defined state at power-up, before any rst.
    state_e           state_q     = StIdle;
    logic [CNT_W-1:0] remaining_q = '0;
    logic [BiteW-1:0] bite_cnt_q  = '0;
    logic             warn_q      = 1'b0;
    logic             bite_q      = 1'b0;
    logic             timed_out_q = 1'b0;

    state_e           state_d;
    logic [CNT_W-1:0] remaining_d;
    logic [BiteW-1:0] bite_cnt_d;
    logic             timed_out_d;
    logic             bite_entry;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bite_cnt_d  = bite_cnt_q;

        case (state_q)
            StIdle: begin
                remaining_d = '0;
                if (wd.enable) begin
                    state_d     = StArmed;
                    remaining_d = TimeoutVal;
                end
            end
            StArmed: begin
                if (!wd.enable) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                end else if (wd.kick) begin
                    remaining_d = TimeoutVal;
                end else begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_d == WarnVal) begin
                        state_d = StWarn;
                    end
                end
            end
            StWarn: begin
                // Priority: disarm, then kick, then expiry.
                if (!wd.enable) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                end else if (wd.kick) begin
                    state_d     = StArmed;
                    remaining_d = TimeoutVal;
                end else if (remaining_q == CNT_W'(1)) begin
                    state_d     = StBite;
                    remaining_d = '0;
                    bite_cnt_d  = '0;
                end else begin
                    remaining_d = remaining_q - 1'b1;
                end
            end
            StBite: begin
                remaining_d = '0;
                if (bite_cnt_q == BiteLast) begin
                    state_d    = StIdle;
                    bite_cnt_d = '0;
                end else begin
                    bite_cnt_d = bite_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                remaining_d = '0;
                bite_cnt_d  = '0;
            end
        endcase
    end

    // A reset on the expiry edge prevents the bite, so it must not record a cause.
    always_comb begin
        bite_entry  = !rst && (state_q == StWarn) && (state_d == StBite);
        timed_out_d = timed_out_q;
        if (bite_entry) begin
            timed_out_d = 1'b1;
        end else if (wd.clear_cause) begin
            timed_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            bite_cnt_q  <= '0;
            warn_q      <= 1'b0;
            bite_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bite_cnt_q  <= bite_cnt_d;
            warn_q      <= (state_d == StWarn);
            bite_q      <= (state_d == StBite);
        end
    end

    always_ff @(posedge clk) begin
        timed_out_q <= timed_out_d;
    end

    assign wd.warn      = warn_q;
    assign wd.bite      = bite_q;
    assign wd.timed_out = timed_out_q;
    assign wd.remaining = remaining_q;

endmodule
